// File: rtl/ahb_master.sv
// AHB-Lite single-transfer initiator: converts a valid/ready request port into
// pipelined NONSEQ transfers, tolerating wait states and two-cycle ERROR responses.
module ahb_master #(
  parameter int unsigned addr_w = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [addr_w-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wd,
  output logic              resp_valid,
  output logic [31:0]       resp_rd,
  output logic              resp_err,
  output logic [addr_w-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  logic              a_valid_q, a_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [addr_w-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rd_q, resp_rd_d;
  logic              resp_err_q, resp_err_d;

  logic accept;
  logic advance;
  logic complete;
  logic hresp_unused;

  // Only the ERROR bit of hresp is meaningful for AHB-Lite.
  assign hresp_unused = hresp[1];

  always_comb begin
    req_rdy  = !a_valid_q || hready;
    accept   = req && req_rdy;
    advance  = a_valid_q && hready;
    complete = d_valid_q && hready;
  end

  // Accept, advance and completion may all fire on one edge; each stage
  // consumes from the one ahead of it, so the ordering below keeps them coherent.
  always_comb begin
    a_valid_d    = a_valid_q;
    d_valid_d    = d_valid_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    wdata_d      = wdata_q;
    hwdata_d     = hwdata_q;
    resp_valid_d = 1'b0;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;

    if (complete) begin
      resp_valid_d = 1'b1;
      resp_rd_d    = hrdata;
      resp_err_d   = hresp[0];
      d_valid_d    = 1'b0;
    end

    if (advance) begin
      d_valid_d = 1'b1;
      a_valid_d = 1'b0;
      if (hwrite_q) begin
        hwdata_d = wdata_q;
      end
    end

    if (accept) begin
      a_valid_d = 1'b1;
      haddr_d   = req_addr;
      hwrite_d  = req_we;
      hsize_d   = req_size;
      wdata_d   = req_wd;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      wdata_q      <= '0;
      hwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      d_valid_q    <= d_valid_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      wdata_q      <= wdata_d;
      hwdata_q     <= hwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    htrans     = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr      = haddr_q;
    hwrite     = hwrite_q;
    hsize      = hsize_q;
    hburst     = '0;
    hwdata     = hwdata_q;
    resp_valid = resp_valid_q;
    resp_rd    = resp_rd_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: directed scenarios plus a randomized run
// checked against a transaction-level queue model with a scripted slave.
module tb_ahb_master;

  logic        hclk;
  logic        hresetn;
  logic        req;
  logic        req_rdy;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic [31:0] resp_rd;
  logic        resp_err;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [31:0] wd;
  } req_t;

  ahb_master #(.addr_w(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req(req), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wd = '0;
    hready = 1'b1; hresp = 2'b00; hrdata = '0;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    idle_inputs();
    #3;
    vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL rst_htrans got=%0h exp=0", htrans); end
    vectors++; if (haddr !== 32'd0) begin miscompares++; $display("FAIL rst_haddr got=%0h exp=0", haddr); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    vectors++; if (hwrite !== 1'b0 || hwdata !== 32'd0 || hsize !== 3'd0) begin miscompares++; $display("FAIL rst_ctrl got=%0b/%0h/%0h exp=0", hwrite, hwdata, hsize); end
    vectors++; if (hburst !== 3'd0) begin miscompares++; $display("FAIL rst_hburst got=%0h exp=0", hburst); end
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_req_rdy got=%0b exp=1", req_rdy); end
    @(negedge hclk);
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 3'd2; req_wd = 32'hA5A5_0001;
    #1;
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL wr_req_rdy got=%0b exp=1", req_rdy); end
    tick(); req = 1'b0; #1;
    vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL wr_htrans got=%0h exp=2", htrans); end
    vectors++; if (haddr !== 32'h10) begin miscompares++; $display("FAIL wr_haddr got=%0h exp=10", haddr); end
    vectors++; if (hwrite !== 1'b1 || hsize !== 3'd2) begin miscompares++; $display("FAIL wr_hwrite_hsize got=%0b/%0h exp=1/2", hwrite, hsize); end
    tick(); #1;
    vectors++; if (hwdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL wr_hwdata got=%0h exp=a5a50001", hwdata); end
    vectors++; if (htrans !== 2'd0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_dphase got=%0h/%0b exp=0/0", htrans, resp_valid); end
    tick(); #1;
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin miscompares++; $display("FAIL wr_resp got=%0b/%0b exp=1/0", resp_valid, resp_err); end
    tick(); #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_resp_strobe got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_read_wait();
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b0; req_addr = 32'h04; req_size = 3'd2;
    tick(); req = 1'b0; #1;
    vectors++; if (htrans !== 2'd2 || haddr !== 32'h04 || hwrite !== 1'b0) begin miscompares++; $display("FAIL rd_aphase got=%0h/%0h/%0b exp=2/4/0", htrans, haddr, hwrite); end
    tick(); hready = 1'b0; #1;
    vectors++; if (haddr !== 32'h04 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_stall1 got=%0h/%0b exp=4/0", haddr, resp_valid); end
    tick(); hready = 1'b0; #1;
    vectors++; if (haddr !== 32'h04 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_stall2 got=%0h/%0b exp=4/0", haddr, resp_valid); end
    tick(); hready = 1'b1; hrdata = 32'hDEAD_BEEF; #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_early_resp got=%0b exp=0", resp_valid); end
    tick(); hrdata = '0; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_rd !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin miscompares++; $display("FAIL rd_resp got=%0b/%0h/%0b exp=1/deadbeef/0", resp_valid, resp_rd, resp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b0; req_size = 3'd2;
    for (int i = 0; i < 6; i++) begin
      req      = (i < 3);
      req_addr = 32'(4 * i);
      hrdata   = (i >= 2 && i <= 4) ? d[i-2] : 32'd0;
      #1;
      if (i >= 1 && i <= 3) begin
        vectors++; if (htrans !== 2'd2 || haddr !== 32'(4 * (i - 1))) begin miscompares++; $display("FAIL b2b_nonseq%0d got=%0h/%0h exp=2/%0h", i, htrans, haddr, 4 * (i - 1)); end
      end
      if (i >= 3) begin
        vectors++; if (resp_valid !== 1'b1 || resp_rd !== d[i-3]) begin miscompares++; $display("FAIL b2b_resp%0d got=%0b/%0h exp=1/%0h", i - 3, resp_valid, resp_rd, d[i-3]); end
      end
      tick();
    end
    #1;
    vectors++; if (resp_valid !== 1'b0 || htrans !== 2'd0) begin miscompares++; $display("FAIL b2b_idle got=%0b/%0h exp=0/0", resp_valid, htrans); end
  endtask

  task automatic test_error();
    logic [31:0] d;
    d = $urandom;
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 3'd2; req_wd = 32'h1234_5678;
    tick();
    req_we = 1'b0; req_addr = 32'h24; #1;
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL err_rdy got=%0b exp=1", req_rdy); end
    tick(); req = 1'b0; hready = 1'b0; hresp = 2'b01; #1;
    vectors++; if (htrans !== 2'd2 || haddr !== 32'h24) begin miscompares++; $display("FAIL err_pending_aphase got=%0h/%0h exp=2/24", htrans, haddr); end
    vectors++; if (hwdata !== 32'h1234_5678) begin miscompares++; $display("FAIL err_hwdata got=%0h exp=12345678", hwdata); end
    tick(); hready = 1'b1; hresp = 2'b01; #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL err_early_resp got=%0b exp=0", resp_valid); end
    tick(); hresp = 2'b00; hrdata = d; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin miscompares++; $display("FAIL err_resp got=%0b/%0b exp=1/1", resp_valid, resp_err); end
    tick(); hrdata = '0; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rd !== d) begin miscompares++; $display("FAIL err_next_okay got=%0b/%0b/%0h exp=1/0/%0h", resp_valid, resp_err, resp_rd, d); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b0; req_size = 3'd2; req_addr = 32'h40;
    tick(); req_addr = 32'h44; #1;
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL stl_rdy_free got=%0b exp=1", req_rdy); end
    tick(); hready = 1'b0; req_addr = 32'h48; #1;
    vectors++; if (req_rdy !== 1'b0) begin miscompares++; $display("FAIL stl_rdy1 got=%0b exp=0", req_rdy); end
    vectors++; if (htrans !== 2'd2 || haddr !== 32'h44) begin miscompares++; $display("FAIL stl_hold1 got=%0h/%0h exp=2/44", htrans, haddr); end
    tick(); #1;
    vectors++; if (req_rdy !== 1'b0 || htrans !== 2'd2 || haddr !== 32'h44) begin miscompares++; $display("FAIL stl_hold2 got=%0b/%0h/%0h exp=0/2/44", req_rdy, htrans, haddr); end
    tick(); hready = 1'b1; hrdata = d[0]; #1;
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL stl_rdy_release got=%0b exp=1", req_rdy); end
    tick(); req = 1'b0; hrdata = d[1]; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_rd !== d[0] || htrans !== 2'd2 || haddr !== 32'h48) begin miscompares++; $display("FAIL stl_r0 got=%0b/%0h/%0h/%0h exp=1/%0h/2/48", resp_valid, resp_rd, htrans, haddr, d[0]); end
    tick(); hrdata = d[2]; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_rd !== d[1]) begin miscompares++; $display("FAIL stl_r1 got=%0b/%0h exp=1/%0h", resp_valid, resp_rd, d[1]); end
    tick(); hrdata = '0; #1;
    vectors++; if (resp_valid !== 1'b1 || resp_rd !== d[2]) begin miscompares++; $display("FAIL stl_r2 got=%0b/%0h exp=1/%0h", resp_valid, resp_rd, d[2]); end
    tick(); #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL stl_done got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_random();
    req_t        aq[$];
    req_t        pr;
    req_t        dp;
    bit          pend;
    bit          dp_act;
    int          dp_wait;
    bit          dp_err;
    logic [31:0] dp_rd;
    bit          rv_due;
    logic [31:0] rv_rd;
    bit          rv_err;
    bit          rv_we;
    bit          hr;
    bit          exp_rdy;
    bit          comp;
    bit          adv;
    int          n_acc;
    int          n_resp;
    pend = 0; dp_act = 0; rv_due = 0; n_acc = 0; n_resp = 0;
    dp_wait = 0; dp_err = 0; dp_rd = '0; rv_rd = '0; rv_err = 0; rv_we = 0;
    idle_inputs(); tick(); tick();
    for (int c = 0; c < 600; c++) begin
      if (dp_act) begin
        hr     = (dp_wait == 0);
        hready = hr;
        hresp  = {1'b0, dp_err && (dp_wait <= 1)};
        hrdata = dp_rd;
      end else begin
        hr = 1'b1; hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
      end
      if (!pend && c < 560 && $urandom_range(0, 3) != 0) begin
        pend    = 1;
        pr.we   = $urandom_range(0, 1);
        pr.size = 3'($urandom_range(0, 2));
        pr.addr = $urandom & ~((32'd1 << pr.size) - 32'd1);
        pr.wd   = $urandom;
      end
      req = pend; req_we = pr.we; req_addr = pr.addr; req_size = pr.size; req_wd = pr.wd;
      #1;
      exp_rdy = (aq.size() == 0) || hr;
      vectors++; if (req_rdy !== exp_rdy) begin miscompares++; $display("FAIL rnd_req_rdy c=%0d got=%0b exp=%0b", c, req_rdy, exp_rdy); end
      if (aq.size() != 0) begin
        vectors++; if (htrans !== 2'd2 || haddr !== aq[0].addr || hwrite !== aq[0].we || hsize !== aq[0].size) begin miscompares++; $display("FAIL rnd_aphase c=%0d got=%0h/%0h/%0b/%0h exp=2/%0h/%0b/%0h", c, htrans, haddr, hwrite, hsize, aq[0].addr, aq[0].we, aq[0].size); end
      end else begin
        vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL rnd_idle c=%0d got=%0h exp=0", c, htrans); end
      end
      if (dp_act && dp.we) begin
        vectors++; if (hwdata !== dp.wd) begin miscompares++; $display("FAIL rnd_hwdata c=%0d got=%0h exp=%0h", c, hwdata, dp.wd); end
      end
      vectors++; if (resp_valid !== rv_due) begin miscompares++; $display("FAIL rnd_resp_valid c=%0d got=%0b exp=%0b", c, resp_valid, rv_due); end
      if (rv_due) begin
        n_resp++;
        vectors++; if (resp_err !== rv_err || (!rv_we && resp_rd !== rv_rd)) begin miscompares++; $display("FAIL rnd_resp c=%0d got=%0b/%0h exp=%0b/%0h", c, resp_err, resp_rd, rv_err, rv_rd); end
      end
      @(posedge hclk);
      comp   = dp_act && hr;
      adv    = (aq.size() != 0) && hr;
      rv_due = comp;
      if (comp) begin rv_rd = dp_rd; rv_err = dp_err; rv_we = dp.we; dp_act = 0; end
      if (dp_act && !hr) dp_wait--;
      if (adv) begin
        dp      = aq.pop_front();
        dp_act  = 1;
        dp_err  = ($urandom_range(0, 5) == 0);
        dp_wait = dp_err ? $urandom_range(1, 2) : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        dp_rd   = $urandom;
      end
      if (pend && exp_rdy) begin aq.push_back(pr); pend = 0; n_acc++; end
      #1;
    end
    vectors++; if (n_resp !== n_acc || n_acc == 0) begin miscompares++; $display("FAIL rnd_count got=%0d exp=%0d", n_resp, n_acc); end
    idle_inputs();
  endtask

  task automatic test_reset_in_data();
    idle_inputs(); tick();
    req = 1'b1; req_we = 1'b0; req_size = 3'd2; req_addr = 32'h30;
    tick(); req_addr = 32'h34;
    tick(); req_addr = 32'h38;
    tick(); req = 1'b0; hready = 1'b0; #1;
    vectors++; if (htrans !== 2'd2 || resp_valid !== 1'b1) begin miscompares++; $display("FAIL rstd_pre got=%0h/%0b exp=2/1", htrans, resp_valid); end
    hresetn = 1'b0; #1;
    vectors++; if (htrans !== 2'd0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rstd_async got=%0h/%0b exp=0/0", htrans, resp_valid); end
    vectors++; if (haddr !== 32'd0 || req_rdy !== 1'b1) begin miscompares++; $display("FAIL rstd_state got=%0h/%0b exp=0/1", haddr, req_rdy); end
    tick(); tick();
    @(negedge hclk);
    hresetn = 1'b1; hready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (resp_valid !== 1'b0 || htrans !== 2'd0) begin miscompares++; $display("FAIL rstd_after%0d got=%0b/%0h exp=0/0", i, resp_valid, htrans); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_error();
    test_stall();
    test_random();
    test_reset_in_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
